// File: rtl/mem_pkg.sv
// Shared state encoding, grant-policy codes and default widths for the memory arbiter.
package mem_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StResp = 2'd2
   } arb_state_e;

   localparam int unsigned ArbFixed      = 0;
   localparam int unsigned ArbRoundRobin = 1;

   localparam int unsigned DefNumCh     = 3;
   localparam int unsigned DefAddrBits  = 16;
   localparam int unsigned DefLineBits  = 128;
   localparam int unsigned DefTimeout   = 64;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant selection: fixed priority (lowest index) or round-robin from ptr_i.
module rr_arbiter
   import mem_pkg::*;
#(
   parameter int unsigned NUM_CH = DefNumCh,
   localparam int unsigned IdxW  = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [IdxW-1:0]   ptr_i,
   input  logic              mode_i,
   output logic [NUM_CH-1:0] grant_o,
   output logic [IdxW-1:0]   idx_o
);

   logic [IdxW-1:0] start;
   int unsigned     cand;
   logic            found;

   // Fixed priority is round-robin search anchored at channel 0.
   assign start = mode_i ? ptr_i : '0;

   // Scan channels from start, wrapping at NUM_CH-1, and take the first requester.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      cand    = 0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         cand = 32'(start) + k;
         if (cand >= NUM_CH) begin
            cand = cand - NUM_CH;
         end
         if (!found && req_i[cand[IdxW-1:0]]) begin
            found                      = 1'b1;
            grant_o[cand[IdxW-1:0]]    = 1'b1;
            idx_o                      = cand[IdxW-1:0];
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates several cache-line requesters onto one backing-memory port, one
// transaction at a time, with an optional downstream timeout.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int unsigned NUM_CH    = DefNumCh,
   parameter int unsigned ADDR_BITS = DefAddrBits,
   parameter int unsigned LINE_BITS = DefLineBits,
   parameter int unsigned ARB_MODE  = ArbRoundRobin,
   parameter int unsigned TIMEOUT   = DefTimeout
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CH-1:0]           ch_req,
   input  logic [NUM_CH-1:0]           ch_we,
   input  logic [NUM_CH*ADDR_BITS-1:0] ch_addr,
   input  logic [NUM_CH*LINE_BITS-1:0] ch_wline,
   output logic [NUM_CH-1:0]           ch_valid,
   output logic [LINE_BITS-1:0]        ch_rline,
   output logic                        ch_err,
   output logic                        dn_req,
   output logic                        dn_we,
   output logic [ADDR_BITS-1:0]        dn_addr,
   output logic [LINE_BITS-1:0]        dn_wline,
   input  logic                        dn_valid,
   input  logic [LINE_BITS-1:0]        dn_rline,
   output logic                        busy
);

   localparam int unsigned IdxW  = $clog2(NUM_CH);
   localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   arb_state_e           state_q;
   logic [IdxW-1:0]      ptr_q;
   logic [IdxW-1:0]      ptr_nxt;
   logic [IdxW-1:0]      grant_idx;
   logic [NUM_CH-1:0]    grant;
   logic [NUM_CH-1:0]    gnt_q;
   logic [WaitW-1:0]     wait_q;
   logic                 timeout_hit;
   logic [NUM_CH-1:0]    ch_valid_q;
   logic [LINE_BITS-1:0] ch_rline_q;
   logic                 ch_err_q;
   logic                 dn_req_q;
   logic                 dn_we_q;
   logic [ADDR_BITS-1:0] dn_addr_q;
   logic [LINE_BITS-1:0] dn_wline_q;

   rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_rr_arbiter (
      .req_i   (ch_req),
      .ptr_i   (ptr_q),
      .mode_i  (ARB_MODE == ArbRoundRobin),
      .grant_o (grant),
      .idx_o   (grant_idx)
   );

   // Pointer moves one past the winner so the winner gets lowest priority next time.
   assign ptr_nxt = (32'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + 1'b1;

   // Fires on the BUSY cycle that would bring the wait count up to TIMEOUT.
   assign timeout_hit = (TIMEOUT != 0) && ((32'(wait_q) + 32'd1) == TIMEOUT);

   // Transaction FSM; all outputs are registered here. dn_valid wins over a same-cycle timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         ptr_q      <= '0;
         gnt_q      <= '0;
         wait_q     <= '0;
         ch_valid_q <= '0;
         ch_rline_q <= '0;
         ch_err_q   <= 1'b0;
         dn_req_q   <= 1'b0;
         dn_we_q    <= 1'b0;
         dn_addr_q  <= '0;
         dn_wline_q <= '0;
      end else begin
         ch_valid_q <= '0;
         ch_err_q   <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (|ch_req) begin
                  gnt_q      <= grant;
                  ptr_q      <= ptr_nxt;
                  wait_q     <= '0;
                  dn_req_q   <= 1'b1;
                  dn_we_q    <= ch_we[grant_idx];
                  dn_addr_q  <= ch_addr[32'(grant_idx) * ADDR_BITS +: ADDR_BITS];
                  dn_wline_q <= ch_wline[32'(grant_idx) * LINE_BITS +: LINE_BITS];
                  state_q    <= StBusy;
               end
            end
            StBusy: begin
               if (dn_valid) begin
                  ch_rline_q <= dn_we_q ? '0 : dn_rline;
                  ch_valid_q <= gnt_q;
                  dn_req_q   <= 1'b0;
                  state_q    <= StResp;
               end else if (timeout_hit) begin
                  ch_rline_q <= '0;
                  ch_valid_q <= gnt_q;
                  ch_err_q   <= 1'b1;
                  dn_req_q   <= 1'b0;
                  state_q    <= StResp;
               end else begin
                  wait_q <= wait_q + 1'b1;
               end
            end
            StResp: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign ch_valid = ch_valid_q;
   assign ch_rline = ch_rline_q;
   assign ch_err   = ch_err_q;
   assign dn_req   = dn_req_q;
   assign dn_we    = dn_we_q;
   assign dn_addr  = dn_addr_q;
   assign dn_wline = dn_wline_q;
   assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 is round-robin, instance 1 fixed priority,
// both with TIMEOUT=8 and a 3-cycle backing-memory model.
module tb_mem_arbiter;

   localparam int unsigned AW     = 16;
   localparam int unsigned LW     = 128;
   localparam int unsigned MemLat = 3;

   typedef struct {
      int unsigned dut;
      int unsigned ch;
      logic [LW-1:0] rline;
      logic err;
   } exp_t;

   logic clk;
   logic rst;
   logic [2:0]      ch_req      [2];
   logic [2:0]      ch_we       [2];
   logic [3*AW-1:0] ch_addr     [2];
   logic [3*LW-1:0] ch_wline    [2];
   logic [2:0]      ch_valid    [2];
   logic [LW-1:0]   ch_rline    [2];
   logic            ch_err      [2];
   logic            dn_req      [2];
   logic            dn_we       [2];
   logic [AW-1:0]   dn_addr     [2];
   logic [LW-1:0]   dn_wline    [2];
   logic            busy        [2];
   logic            force_valid [2];
   logic            mem_en      [2];

   int errors = 0;
   int checks = 0;
   exp_t sb[$];
   exp_t mon_e;

   function automatic logic [LW-1:0] mem_data(input logic [AW-1:0] a);
      return {8{a ^ 16'hA5B5}};
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic          mem_valid = 1'b0;
      logic          mem_busy  = 1'b0;
      int unsigned   mem_cnt   = 0;
      logic [LW-1:0] mem_rdata = '0;

      mem_arbiter #(
         .NUM_CH    (3),
         .ADDR_BITS (AW),
         .LINE_BITS (LW),
         .ARB_MODE  ((g == 0) ? 1 : 0),
         .TIMEOUT   (8)
      ) u_dut (
         .clk      (clk),
         .rst      (rst),
         .ch_req   (ch_req[g]),
         .ch_we    (ch_we[g]),
         .ch_addr  (ch_addr[g]),
         .ch_wline (ch_wline[g]),
         .ch_valid (ch_valid[g]),
         .ch_rline (ch_rline[g]),
         .ch_err   (ch_err[g]),
         .dn_req   (dn_req[g]),
         .dn_we    (dn_we[g]),
         .dn_addr  (dn_addr[g]),
         .dn_wline (dn_wline[g]),
         .dn_valid (mem_valid | force_valid[g]),
         .dn_rline (mem_rdata),
         .busy     (busy[g])
      );

      // Backing memory: accepts dn_req, answers MemLat cycles after acceptance.
      always @(posedge clk) begin
         mem_valid <= 1'b0;
         if (mem_busy) begin
            if (mem_cnt == 1) begin
               mem_valid <= 1'b1;
               mem_busy  <= 1'b0;
            end else begin
               mem_cnt <= mem_cnt - 1;
            end
         end else if (mem_en[g] && dn_req[g] && !mem_valid) begin
            mem_busy  <= 1'b1;
            mem_cnt   <= MemLat;
            mem_rdata <= mem_data(dn_addr[g]);
         end
      end
   end

   // Scoreboard: every completion pulse must match the oldest expected entry.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (ch_valid[d] != 3'b000) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected dut%0d: got ch_valid=%b, required no pulse",
                        d, ch_valid[d]);
            end else begin
               mon_e = sb.pop_front();
               if (mon_e.dut != d || ch_valid[d] !== (3'b001 << mon_e.ch) ||
                   ch_rline[d] !== mon_e.rline || ch_err[d] !== mon_e.err) begin
                  errors++;
                  $display("FAIL sb_compare dut%0d: got ch_valid=%b rline=%h err=%b, required dut%0d ch%0d rline=%h err=%b",
                           d, ch_valid[d], ch_rline[d], ch_err[d], mon_e.dut, mon_e.ch,
                           mon_e.rline, mon_e.err);
               end
            end
         end
      end
   end

   task automatic apply_reset();
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         ch_req[d]      = '0;
         ch_we[d]       = '0;
         ch_addr[d]     = '0;
         ch_wline[d]    = '0;
         force_valid[d] = 1'b0;
         mem_en[d]      = 1'b1;
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Requesters drop ch_req in the cycle after their ch_valid.
   task automatic run_until_idle(input int d, input int budget, output int pulses);
      logic [2:0] drop;
      int cyc;
      drop   = '0;
      pulses = 0;
      cyc    = 0;
      while (cyc < budget && !(ch_req[d] == 3'b000 && !busy[d])) begin
         @(negedge clk);
         if (ch_valid[d] != 3'b000) pulses++;
         drop = drop | ch_valid[d];
         @(posedge clk);
         #1;
         ch_req[d] = ch_req[d] & ~drop;
         drop      = '0;
         cyc++;
      end
      checks++;
      if (cyc >= budget) begin
         errors++;
         $display("FAIL idle_budget dut%0d: got still busy after %0d cycles, required idle", d, cyc);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         ch_req[d] = '0; ch_we[d] = '0; ch_addr[d] = '0; ch_wline[d] = '0;
         force_valid[d] = 1'b0; mem_en[d] = 1'b1;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({dn_req[d], dn_we[d], ch_err[d], busy[d], ch_valid[d]} !== 7'b0 ||
             dn_addr[d] !== '0 || dn_wline[d] !== '0 || ch_rline[d] !== '0) begin
            errors++;
            $display("FAIL reset_outputs dut%0d: got req=%b we=%b err=%b busy=%b valid=%b addr=%h, required all 0",
                     d, dn_req[d], dn_we[d], ch_err[d], busy[d], ch_valid[d], dn_addr[d]);
         end
      end
      rst = 1'b0;
      // dn_valid while idle must not produce anything.
      @(posedge clk);
      #1 force_valid[0] = 1'b1;
      @(posedge clk);
      #1 force_valid[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (busy[0] !== 1'b0 || ch_valid[0] !== 3'b000) begin
            errors++;
            $display("FAIL idle_dn_valid_ignored: got busy=%b ch_valid=%b, required 0 000",
                     busy[0], ch_valid[0]);
         end
      end
   endtask

   task automatic test_single_read();
      int n;
      apply_reset();
      ch_addr[0][15:0] = 16'h0010;
      sb.push_back('{dut: 0, ch: 0, rline: {8{16'hA5A5}}, err: 1'b0});
      ch_req[0] = 3'b001;
      checks++;
      if (dn_req[0] !== 1'b0) begin
         errors++;
         $display("FAIL single_dn_req_early: got %b, required 0", dn_req[0]);
      end
      n = 0;
      while (n < 20) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (n == 1) begin
            checks++;
            if ({dn_req[0], busy[0], dn_we[0]} !== 3'b110 || dn_addr[0] !== 16'h0010) begin
               errors++;
               $display("FAIL single_issue: got req/busy/we=%b%b%b addr=%h, required 110 0010",
                        dn_req[0], busy[0], dn_we[0], dn_addr[0]);
            end
         end
         if (ch_valid[0] != 3'b000) break;
      end
      checks++;
      if (n !== 6) begin
         errors++;
         $display("FAIL single_latency: got %0d cycles, required 6", n);
      end
      @(posedge clk);
      #1 ch_req[0] = '0;
      @(negedge clk);
      checks++;
      if (ch_valid[0] !== 3'b000) begin
         errors++;
         $display("FAIL single_pulse_width: got ch_valid=%b, required 000", ch_valid[0]);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL single_sb_drain: got %0d pending, required 0", sb.size());
      end
   endtask

   task automatic test_rr_contention();
      int pulses;
      apply_reset();
      for (int i = 0; i < 3; i++) ch_addr[0][i*AW +: AW] = 16'h0100 + 16'(i);
      for (int i = 0; i < 3; i++) begin
         sb.push_back('{dut: 0, ch: i, rline: mem_data(16'h0100 + 16'(i)), err: 1'b0});
      end
      ch_req[0] = 3'b111;
      run_until_idle(0, 60, pulses);
      checks++;
      if (pulses !== 3 || sb.size() != 0) begin
         errors++;
         $display("FAIL rr_three_pulses: got %0d pulses %0d pending, required 3 0", pulses, sb.size());
      end
      // After a grant to 0 the pointer sits at 1, so 2 beats 0 next.
      apply_reset();
      ch_addr[0][0 +: AW]    = 16'h0200;
      ch_addr[0][2*AW +: AW] = 16'h0202;
      sb.push_back('{dut: 0, ch: 0, rline: mem_data(16'h0200), err: 1'b0});
      ch_req[0] = 3'b001;
      run_until_idle(0, 30, pulses);
      sb.push_back('{dut: 0, ch: 2, rline: mem_data(16'h0202), err: 1'b0});
      sb.push_back('{dut: 0, ch: 0, rline: mem_data(16'h0200), err: 1'b0});
      ch_req[0] = 3'b101;
      run_until_idle(0, 40, pulses);
      checks++;
      if (pulses !== 2 || sb.size() != 0) begin
         errors++;
         $display("FAIL rr_wrap: got %0d pulses %0d pending, required 2 0", pulses, sb.size());
      end
   endtask

   task automatic test_fixed();
      int pulses;
      apply_reset();
      for (int i = 0; i < 3; i++) ch_addr[1][i*AW +: AW] = 16'h0300 + 16'(i);
      sb.push_back('{dut: 1, ch: 1, rline: mem_data(16'h0301), err: 1'b0});
      sb.push_back('{dut: 1, ch: 0, rline: mem_data(16'h0300), err: 1'b0});
      sb.push_back('{dut: 1, ch: 2, rline: mem_data(16'h0302), err: 1'b0});
      ch_req[1] = 3'b110;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (busy[1] !== 1'b1 || dn_addr[1] !== 16'h0301) begin
         errors++;
         $display("FAIL fixed_first_grant: got busy=%b addr=%h, required 1 0301", busy[1], dn_addr[1]);
      end
      ch_req[1] = ch_req[1] | 3'b001;
      run_until_idle(1, 60, pulses);
      checks++;
      if (pulses !== 3 || sb.size() != 0) begin
         errors++;
         $display("FAIL fixed_order: got %0d pulses %0d pending, required 3 0", pulses, sb.size());
      end
   endtask

   task automatic test_write();
      int n;
      apply_reset();
      ch_we[0]                 = 3'b100;
      ch_addr[0][2*AW +: AW]   = 16'h0003;
      ch_wline[0][2*LW +: LW]  = 128'h1234;
      sb.push_back('{dut: 0, ch: 2, rline: '0, err: 1'b0});
      ch_req[0] = 3'b100;
      n = 0;
      while (n < 20) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (ch_valid[0] != 3'b000) break;
         checks++;
         if ({dn_req[0], dn_we[0]} !== 2'b11 || dn_addr[0] !== 16'h0003 ||
             dn_wline[0] !== 128'h1234) begin
            errors++;
            $display("FAIL write_cmd_stable cycle %0d: got req/we=%b%b addr=%h wline=%h, required 11 0003 1234",
                     n, dn_req[0], dn_we[0], dn_addr[0], dn_wline[0]);
         end
      end
      checks++;
      if (dn_req[0] !== 1'b0) begin
         errors++;
         $display("FAIL write_dn_req_drop: got %b, required 0", dn_req[0]);
      end
      @(posedge clk);
      #1 ch_req[0] = '0;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_timeout();
      int n;
      apply_reset();
      mem_en[0]        = 1'b0;
      ch_addr[0][15:0] = 16'h0020;
      sb.push_back('{dut: 0, ch: 0, rline: '0, err: 1'b1});
      ch_req[0] = 3'b001;
      @(posedge clk);
      n = 0;
      while (n < 30) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (ch_valid[0] != 3'b000) break;
      end
      checks++;
      if (n !== 8) begin
         errors++;
         $display("FAIL timeout_cycles: got %0d busy cycles, required 8", n);
      end
      checks++;
      if (dn_req[0] !== 1'b0 || ch_err[0] !== 1'b1) begin
         errors++;
         $display("FAIL timeout_outputs: got dn_req=%b ch_err=%b, required 0 1", dn_req[0], ch_err[0]);
      end
      @(posedge clk);
      #1 ch_req[0] = '0;
      mem_en[0] = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_reset_busy();
      int pulses;
      apply_reset();
      ch_addr[0][15:0] = 16'h0040;
      ch_req[0] = 3'b001;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst       = 1'b1;
      ch_req[0] = '0;
      #1;
      checks++;
      if ({dn_req[0], dn_we[0], ch_err[0], busy[0], ch_valid[0]} !== 7'b0 ||
          dn_addr[0] !== '0 || dn_wline[0] !== '0 || ch_rline[0] !== '0) begin
         errors++;
         $display("FAIL reset_in_busy: got req=%b busy=%b addr=%h valid=%b, required all 0",
                  dn_req[0], busy[0], dn_addr[0], ch_valid[0]);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (ch_valid[0] != 3'b000) pulses++;
      end
      checks++;
      if (pulses !== 0 || busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL reset_abandon: got %0d pulses busy=%b, required 0 0", pulses, busy[0]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, required finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_read();
      test_rr_contention();
      test_fixed();
      test_write();
      test_timeout();
      test_reset_busy();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL final_sb_drain: got %0d pending, required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of requesting channels (icache, dcache, ptw); legal 2..8.
REQ-002 SHALL have parameter ADDR_BITS, default 16, line address width.
REQ-003 SHALL have parameter LINE_BITS, default 128, line data width.
REQ-004 SHALL have parameter ARB_MODE, default 1, grant policy: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-005 SHALL have parameter TIMEOUT, default 64, maximum wait cycles for dn_valid; 0 disables the timeout.
REQ-006 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port ch_req, input, NUM_CH, per-channel request, held high until that channel's ch_valid.
REQ-009 SHALL have port ch_we, input, NUM_CH, per-channel write (1) / line-read (0) flag.
REQ-010 SHALL have port ch_addr, input, NUM_CH*ADDR_BITS, flat per-channel addresses; channel i at slice i.
REQ-011 SHALL have port ch_wline, input, NUM_CH*LINE_BITS, flat per-channel write lines.
REQ-012 SHALL have port ch_valid, output, NUM_CH, one-cycle completion pulse to the granted channel.
REQ-013 SHALL have port ch_rline, output, LINE_BITS, read line shared by all channels, valid with ch_valid.
REQ-014 SHALL have port ch_err, output, 1, pulses with ch_valid when the transaction timed out.
REQ-015 SHALL have port dn_req, output, 1, request to backing memory, held until dn_valid.
REQ-016 SHALL have ports dn_we (output, 1), dn_addr (output, ADDR_BITS) and dn_wline (output, LINE_BITS), which form the registered downstream command.
REQ-017 SHALL have ports dn_valid (input, 1) and dn_rline (input, LINE_BITS), the backing memory completion pulse and read data.
REQ-018 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-019 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE.
REQ-020 In IDLE, with any ch_req high, SHALL select grant g per ARB_MODE, register ch_we[g], ch_addr[g] and ch_wline[g] into the dn_* outputs, and enter BUSY; dn_req SHALL rise the cycle after ch_req is sampled.
REQ-021 In BUSY, dn_req and dn_* SHALL stay constant; on dn_valid SHALL capture dn_rline (reads only; writes capture zero) and enter RESP.
REQ-022 In RESP, ch_valid[g] = 1 for exactly one cycle, all other ch_valid = 0, dn_req = 0; next state SHALL be IDLE.
REQ-023 Round-robin pointer SHALL update to g+1 (mod NUM_CH) on each grant; the search starts at the pointer and wraps from NUM_CH-1 to 0.
REQ-024 Fixed mode SHALL ignore the pointer.
REQ-025 Request-to-valid latency SHALL be downstream latency + 3 cycles (grant, RESP, plus one dn_req issue cycle).
REQ-026 A wait counter SHALL count BUSY cycles; if TIMEOUT != 0 and it reaches TIMEOUT without dn_valid, SHALL enter RESP with ch_rline = 0 and ch_err = 1, and drop dn_req.
REQ-027 dn_valid outside BUSY SHALL be ignored.
REQ-028 dn_valid in the same cycle the counter reaches TIMEOUT SHALL count as success, with ch_err = 0.
REQ-029 Requests arriving during BUSY or RESP SHALL wait; none is lost as long as the requester holds it.
REQ-030 A requester SHALL drop ch_req in the cycle after its ch_valid; the arbiter re-samples only in IDLE.

Reset
REQ-031 On rst, state = IDLE, pointer = 0, wait counter = 0, and dn_req, dn_we, dn_addr, dn_wline, ch_valid, ch_rline, ch_err and busy all = 0, immediately and asynchronously.
REQ-032 Reset during BUSY SHALL abandon the transaction without any ch_valid pulse.

Structure
REQ-033 State encoding, the ARB_MODE codes and the default widths SHALL live in shared package mem_pkg.
REQ-034 Grant selection SHALL be one sub-module, rr_arbiter, which is combinational with pointer and mode inputs and outputs a one-hot grant plus its index.

Verification
REQ-035 Single read: ch_req=001, ch_addr[0]=0x0010, memory latency 3 returns 0xA5..A5 -> ch_valid=001 once, ch_rline=0xA5..A5, 6 cycles after ch_req.
REQ-036 Round-robin contention: ch_req=111 held, each requester dropping after its valid -> grant order 0,1,2, three ch_valid pulses, no overlap.
REQ-037 Fixed mode with ch_req=110 and then ch_req[0] rising mid-BUSY -> grant 1, then 0, then 2.
REQ-038 Write: ch_we[2]=1, addr 0x0003, wline 0x1234 -> dn_we=1, dn_addr=0x0003, dn_wline=0x1234 stable until dn_valid; ch_rline=0.
REQ-039 Timeout with TIMEOUT=8 and no dn_valid -> ch_valid and ch_err pulse 8 cycles into BUSY, ch_rline=0, dn_req low the same cycle.
REQ-040 rst asserted in BUSY cycle 2 -> outputs 0 immediately; a later dn_valid is ignored and there is no ch_valid.
